sys_tx_sched: RTL and testbench

Transmit-side scheduler for the system controller. It shares the single UART transmitter between two requesters: register-file read data (1 byte) and ALU results (2 bytes).
- Each result is captured in its own hold slot.
- Slots are served with fixed priority.
- ALU results are split into low byte then high byte.
- Each byte is handed to UART TX with a valid/busy handshake and a busy-rise timeout.

---
 rtl/sys_tx_sched_pkg.sv | 15 +
 rtl/sys_tx_sched_slot.sv | 44 ++++
 rtl/sys_tx_sched.sv | 159 +++++++++++++++
 tb/tb_sys_tx_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_tx_sched_pkg.sv
// sys_tx_sched_pkg
//   Shared definitions for the transmit-side scheduler: scheduler state
//   encoding and the default busy-rise timeout.
package sys_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SEND      = 2'b01,
        WAIT_RISE = 2'b10,
        WAIT_FALL = 2'b11
    } sched_state_t;

    localparam int unsigned BUSY_TO_DEFAULT = 15;

endpackage

// File: rtl/sys_tx_sched_slot.sv
// tx_hold_slot
//   Single-entry hold register for one requester of the UART transmitter.
//   Ports:
//     clck    - system clock, rising edge
//     rst     - asynchronous active-low reset
//     strobe  - one-cycle capture strobe for din
//     din     - incoming data
//     load    - scheduler takes the slot contents this cycle (frees the slot)
//     full    - slot holds data not yet taken
//     dout    - held data
//     overrun - one-cycle pulse, a strobe hit a full slot and was dropped
module tx_hold_slot
    import sys_tx_sched_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clck,
    input  logic          rst,
    input  logic          strobe,
    input  logic [DW-1:0] din,
    input  logic          load,
    output logic          full,
    output logic [DW-1:0] dout,
    output logic          overrun
);

    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            full    <= 1'b0;
            dout    <= '0;
            overrun <= 1'b0;
        end else begin
            // A slot being emptied this cycle can accept new data at once.
            overrun <= strobe && full && !load;
            if (strobe && (!full || load)) begin
                dout <= din;
                full <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sys_tx_sched.sv
// sys_tx_sched
//   Shares the UART transmitter between register-file read data (1 byte)
//   and ALU results (2 bytes, low byte first). Register-file data has fixed
//   priority. Each byte is offered with tx_valid while tx_busy is low; if
//   tx_busy does not rise within BUSY_TO cycles the byte is taken as sent.
//   Ports:
//     clck, rst              - clock, asynchronous active-low reset
//     RdData, RdData_valid   - register-file data and its strobe
//     ALU_OUT, ALU_OUT_valid - ALU result and its strobe
//     tx_busy                - UART TX busy
//     tx_data, tx_valid      - byte to UART TX and its one-cycle strobe
//     frame_done             - pulse when the last byte of a result completes
//     overrun                - pulse when an incoming result is dropped
//     sched_busy             - scheduler active or a slot is occupied
module sys_tx_sched
    import sys_tx_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned BUSY_TO = BUSY_TO_DEFAULT
) (
    input  logic               clck,
    input  logic               rst,
    input  logic [WIDTH-1:0]   RdData,
    input  logic               RdData_valid,
    input  logic [2*WIDTH-1:0] ALU_OUT,
    input  logic               ALU_OUT_valid,
    input  logic               tx_busy,
    output logic [WIDTH-1:0]   tx_data,
    output logic               tx_valid,
    output logic               frame_done,
    output logic               overrun,
    output logic               sched_busy
);

    localparam int unsigned       CW      = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
    localparam logic [CW-1:0]     TO_LAST = CW'(BUSY_TO - 1);

    sched_state_t       state_q, state_d;
    logic [WIDTH-1:0]   hi_reg;
    logic               bytes_left;
    logic [CW-1:0]      to_cnt;

    logic               rf_full, alu_full;
    logic [WIDTH-1:0]   rf_data;
    logic [2*WIDTH-1:0] alu_data;
    logic               rf_overrun, alu_overrun;

    logic               ld_rf, ld_alu, ld_hi;
    logic               cnt_clr, cnt_inc;
    logic               byte_done;

    tx_hold_slot #(.DW(WIDTH)) u_rf_slot (
        .clck    (clck),
        .rst     (rst),
        .strobe  (RdData_valid),
        .din     (RdData),
        .load    (ld_rf),
        .full    (rf_full),
        .dout    (rf_data),
        .overrun (rf_overrun)
    );

    tx_hold_slot #(.DW(2*WIDTH)) u_alu_slot (
        .clck    (clck),
        .rst     (rst),
        .strobe  (ALU_OUT_valid),
        .din     (ALU_OUT),
        .load    (ld_alu),
        .full    (alu_full),
        .dout    (alu_data),
        .overrun (alu_overrun)
    );

    // State register
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        ld_rf     = 1'b0;
        ld_alu    = 1'b0;
        ld_hi     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        byte_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rf_full) begin
                    ld_rf   = 1'b1;
                    state_d = SEND;
                end else if (alu_full) begin
                    ld_alu  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    cnt_clr = 1'b1;
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (tx_busy)                state_d   = WAIT_FALL;
                else if (to_cnt == TO_LAST) byte_done = 1'b1;
                else                        cnt_inc   = 1'b1;
            end
            WAIT_FALL: begin
                if (!tx_busy) byte_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Timeout in WAIT_RISE shares the WAIT_FALL exit action.
        if (byte_done) begin
            if (bytes_left) begin
                ld_hi   = 1'b1;
                state_d = SEND;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Outputs
    always_comb begin
        tx_valid   = (state_q == SEND) && !tx_busy;
        frame_done = byte_done && !bytes_left;
        overrun    = rf_overrun || alu_overrun;
        sched_busy = (state_q != IDLE) || rf_full || alu_full;
    end

    // tx_data doubles as the current-byte register: it is loaded only when
    // a new byte is selected, so it holds its value between sends.
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            tx_data    <= '0;
            hi_reg     <= '0;
            bytes_left <= 1'b0;
            to_cnt     <= '0;
        end else begin
            if (ld_rf) begin
                tx_data    <= rf_data;
                bytes_left <= 1'b0;
            end else if (ld_alu) begin
                tx_data    <= alu_data[WIDTH-1:0];
                hi_reg     <= alu_data[2*WIDTH-1:WIDTH];
                bytes_left <= 1'b1;
            end else if (ld_hi) begin
                tx_data    <= hi_reg;
                bytes_left <= 1'b0;
            end
            if (cnt_clr)      to_cnt <= '0;
            else if (cnt_inc) to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sys_tx_sched.sv
module tb_sys_tx_sched;

    logic        clck = 1'b0;
    logic        rst;
    logic [7:0]  RdData;
    logic        RdData_valid;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_valid;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        frame_done;
    logic        overrun;
    logic        sched_busy;

    int n_cmp = 0;
    int n_err = 0;

    sys_tx_sched #(.WIDTH(8), .BUSY_TO(15)) dut (
        .clck          (clck),
        .rst           (rst),
        .RdData        (RdData),
        .RdData_valid  (RdData_valid),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_valid (ALU_OUT_valid),
        .tx_busy       (tx_busy),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .sched_busy    (sched_busy)
    );

    always #5 clck = ~clck;

    int cyc = 0;
    always @(posedge clck) cyc <= cyc + 1;

    // UART model: busy rises one cycle after tx_valid, stays high 10 cycles.
    logic auto_busy   = 1'b1;
    logic manual_busy = 1'b0;
    logic busy_model  = 1'b0;
    int   busy_left   = 0;
    int   valid_cnt   = 0;
    int   seen_cnt    = 0;
    assign tx_busy = busy_model | manual_busy;

    always @(posedge clck) begin
        #1;
        if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) busy_model = 1'b0;
        end
        if (auto_busy && valid_cnt != seen_cnt) begin
            busy_model = 1'b1;
            busy_left  = 10;
        end
        seen_cnt = valid_cnt;
    end

    // Event log, sampled mid-cycle.
    logic [7:0] sent_q[$];
    int         vcyc_q[$];
    int         frame_cnt  = 0;
    int         last_frame = 0;
    int         ovr_cnt    = 0;

    always @(negedge clck) begin
        if (rst) begin
            if (tx_valid) begin
                sent_q.push_back(tx_data);
                vcyc_q.push_back(cyc);
                valid_cnt = valid_cnt + 1;
            end
            if (frame_done) begin
                frame_cnt  = frame_cnt + 1;
                last_frame = cyc;
            end
            if (overrun) ovr_cnt = ovr_cnt + 1;
        end
    end

    task automatic strobe(input logic rf, input logic [7:0] rd,
                          input logic alu, input logic [15:0] ad,
                          output int n);
        @(negedge clck);
        RdData        = rd;
        RdData_valid  = rf;
        ALU_OUT       = ad;
        ALU_OUT_valid = alu;
        n = cyc;
        @(negedge clck);
        RdData_valid  = 1'b0;
        ALU_OUT_valid = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clck);
            if (!sched_busy && !tx_busy && busy_left == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clck);
    endtask

    task automatic test_reset;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", overrun); end
        n_cmp++; if (sched_busy !== 1'b0) begin n_err++; $display("FAIL reset_sched_busy got %b want 0", sched_busy); end
    endtask

    task automatic test_rf_byte;
        int s0, f0, o0, n; logic ok;
        s0 = sent_q.size(); f0 = frame_cnt; o0 = ovr_cnt;
        strobe(1'b1, 8'hA5, 1'b0, 16'h0, n);
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rf_idle_timeout got %b want 1", ok); end
        n_cmp++; if (sent_q.size() - s0 != 1) begin n_err++; $display("FAIL rf_count got %0d want 1", sent_q.size() - s0); end
        if (sent_q.size() > s0) begin
            n_cmp++; if (sent_q[s0] !== 8'hA5) begin n_err++; $display("FAIL rf_data got %h want a5", sent_q[s0]); end
            n_cmp++; if (vcyc_q[s0] != n + 2) begin n_err++; $display("FAIL rf_latency got %0d want %0d", vcyc_q[s0], n + 2); end
        end
        n_cmp++; if (frame_cnt - f0 != 1) begin n_err++; $display("FAIL rf_frames got %0d want 1", frame_cnt - f0); end
        n_cmp++; if (last_frame != n + 13) begin n_err++; $display("FAIL rf_frame_cycle got %0d want %0d", last_frame, n + 13); end
        n_cmp++; if (ovr_cnt - o0 != 0) begin n_err++; $display("FAIL rf_overrun got %0d want 0", ovr_cnt - o0); end
    endtask

    task automatic test_alu_split;
        int s0, f0, n; logic ok;
        logic [7:0] exp_b[2];
        exp_b[0] = 8'h34; exp_b[1] = 8'h12;
        s0 = sent_q.size(); f0 = frame_cnt;
        strobe(1'b0, 8'h0, 1'b1, 16'h1234, n);
        wait_idle(ok);
        n_cmp++; if (sent_q.size() - s0 != 2) begin n_err++; $display("FAIL alu_count got %0d want 2", sent_q.size() - s0); end
        for (int i = 0; i < 2; i++) begin
            if (sent_q.size() > s0 + i) begin
                n_cmp++; if (sent_q[s0+i] !== exp_b[i]) begin n_err++; $display("FAIL alu_byte%0d got %h want %h", i, sent_q[s0+i], exp_b[i]); end
            end
        end
        if (sent_q.size() >= s0 + 2) begin
            n_cmp++; if (vcyc_q[s0] != n + 2) begin n_err++; $display("FAIL alu_lo_cycle got %0d want %0d", vcyc_q[s0], n + 2); end
            n_cmp++; if (vcyc_q[s0+1] != n + 14) begin n_err++; $display("FAIL alu_hi_cycle got %0d want %0d", vcyc_q[s0+1], n + 14); end
        end
        n_cmp++; if (frame_cnt - f0 != 1) begin n_err++; $display("FAIL alu_frames got %0d want 1", frame_cnt - f0); end
        n_cmp++; if (last_frame != n + 25) begin n_err++; $display("FAIL alu_frame_cycle got %0d want %0d", last_frame, n + 25); end
    endtask

    task automatic test_back_to_back;
        int s0, f0, o0, n; logic ok;
        logic [7:0] exp_b[3];
        exp_b[0] = 8'h11; exp_b[1] = 8'hEF; exp_b[2] = 8'hBE;
        s0 = sent_q.size(); f0 = frame_cnt; o0 = ovr_cnt;
        strobe(1'b1, 8'h11, 1'b1, 16'hBEEF, n);
        wait_idle(ok);
        n_cmp++; if (sent_q.size() - s0 != 3) begin n_err++; $display("FAIL both_count got %0d want 3", sent_q.size() - s0); end
        for (int i = 0; i < 3; i++) begin
            if (sent_q.size() > s0 + i) begin
                n_cmp++; if (sent_q[s0+i] !== exp_b[i]) begin n_err++; $display("FAIL both_byte%0d got %h want %h", i, sent_q[s0+i], exp_b[i]); end
            end
        end
        n_cmp++; if (frame_cnt - f0 != 2) begin n_err++; $display("FAIL both_frames got %0d want 2", frame_cnt - f0); end
        n_cmp++; if (ovr_cnt - o0 != 0) begin n_err++; $display("FAIL both_overrun got %0d want 0", ovr_cnt - o0); end
    endtask

    task automatic test_overrun;
        int s0, f0, o0, n, n2, n3; logic ok;
        logic [7:0] exp_b[4];
        exp_b[0] = 8'h01; exp_b[1] = 8'h00; exp_b[2] = 8'h02; exp_b[3] = 8'h00;
        s0 = sent_q.size(); f0 = frame_cnt; o0 = ovr_cnt;
        strobe(1'b0, 8'h0, 1'b1, 16'h0001, n);
        repeat (2) @(negedge clck);
        strobe(1'b0, 8'h0, 1'b1, 16'h0002, n2);
        @(negedge clck);
        n_cmp++; if (ovr_cnt - o0 != 0) begin n_err++; $display("FAIL ovr_early got %0d want 0", ovr_cnt - o0); end
        RdData = 8'h0; ALU_OUT = 16'h0003; ALU_OUT_valid = 1'b1; n3 = cyc;
        @(negedge clck);
        ALU_OUT_valid = 1'b0;
        wait_idle(ok);
        n_cmp++; if (ovr_cnt - o0 != 1) begin n_err++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - o0); end
        n_cmp++; if (sent_q.size() - s0 != 4) begin n_err++; $display("FAIL ovr_count got %0d want 4", sent_q.size() - s0); end
        for (int i = 0; i < 4; i++) begin
            if (sent_q.size() > s0 + i) begin
                n_cmp++; if (sent_q[s0+i] !== exp_b[i]) begin n_err++; $display("FAIL ovr_byte%0d got %h want %h", i, sent_q[s0+i], exp_b[i]); end
            end
        end
        n_cmp++; if (frame_cnt - f0 != 2) begin n_err++; $display("FAIL ovr_frames got %0d want 2", frame_cnt - f0); end
    endtask

    task automatic test_timeout;
        int s0, f0, n, k; logic ok;
        auto_busy = 1'b0;
        s0 = sent_q.size(); f0 = frame_cnt;
        strobe(1'b1, 8'h77, 1'b0, 16'h0, n);
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL to_idle_timeout got %b want 1", ok); end
        n_cmp++; if (sent_q.size() - s0 != 1) begin n_err++; $display("FAIL to_count got %0d want 1", sent_q.size() - s0); end
        n_cmp++; if (frame_cnt - f0 != 1) begin n_err++; $display("FAIL to_frames got %0d want 1", frame_cnt - f0); end
        n_cmp++; if (last_frame != n + 17) begin n_err++; $display("FAIL to_frame_cycle got %0d want %0d", last_frame, n + 17); end
        // busy held high while the byte waits in SEND
        s0 = sent_q.size();
        manual_busy = 1'b1;
        strobe(1'b1, 8'h3C, 1'b0, 16'h0, n);
        repeat (6) @(negedge clck);
        n_cmp++; if (sent_q.size() - s0 != 0) begin n_err++; $display("FAIL hold_no_valid got %0d want 0", sent_q.size() - s0); end
        @(posedge clck); #1;
        manual_busy = 1'b0;
        k = cyc;
        wait_idle(ok);
        n_cmp++; if (sent_q.size() - s0 != 1) begin n_err++; $display("FAIL hold_count got %0d want 1", sent_q.size() - s0); end
        if (sent_q.size() > s0) begin
            n_cmp++; if (sent_q[s0] !== 8'h3C) begin n_err++; $display("FAIL hold_data got %h want 3c", sent_q[s0]); end
            n_cmp++; if (vcyc_q[s0] != k) begin n_err++; $display("FAIL hold_cycle got %0d want %0d", vcyc_q[s0], k); end
        end
        n_cmp++; if (last_frame != k + 15) begin n_err++; $display("FAIL hold_frame_cycle got %0d want %0d", last_frame, k + 15); end
        auto_busy = 1'b1;
    endtask

    task automatic test_reset_mid;
        int s0, f0, n; logic ok;
        s0 = sent_q.size(); f0 = frame_cnt;
        strobe(1'b0, 8'h0, 1'b1, 16'hCAFE, n);
        while (cyc < n + 6) @(negedge clck);
        rst = 1'b0;
        #1;
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rmid_tx_data got %h want 00", tx_data); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rmid_tx_valid got %b want 0", tx_valid); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rmid_frame_done got %b want 0", frame_done); end
        n_cmp++; if (sched_busy !== 1'b0) begin n_err++; $display("FAIL rmid_sched_busy got %b want 0", sched_busy); end
        repeat (2) @(negedge clck);
        rst = 1'b1;
        wait_idle(ok);
        n_cmp++; if (sent_q.size() - s0 != 1) begin n_err++; $display("FAIL rmid_count got %0d want 1", sent_q.size() - s0); end
        if (sent_q.size() > s0) begin
            n_cmp++; if (sent_q[s0] !== 8'hFE) begin n_err++; $display("FAIL rmid_lo got %h want fe", sent_q[s0]); end
        end
        n_cmp++; if (frame_cnt - f0 != 0) begin n_err++; $display("FAIL rmid_frames got %0d want 0", frame_cnt - f0); end
        s0 = sent_q.size(); f0 = frame_cnt;
        strobe(1'b1, 8'h5A, 1'b0, 16'h0, n);
        wait_idle(ok);
        n_cmp++; if (sent_q.size() - s0 != 1) begin n_err++; $display("FAIL rmid_after_count got %0d want 1", sent_q.size() - s0); end
        if (sent_q.size() > s0) begin
            n_cmp++; if (sent_q[s0] !== 8'h5A) begin n_err++; $display("FAIL rmid_after_data got %h want 5a", sent_q[s0]); end
            n_cmp++; if (vcyc_q[s0] != n + 2) begin n_err++; $display("FAIL rmid_after_cycle got %0d want %0d", vcyc_q[s0], n + 2); end
        end
        n_cmp++; if (frame_cnt - f0 != 1) begin n_err++; $display("FAIL rmid_after_frames got %0d want 1", frame_cnt - f0); end
    endtask

    initial begin
        rst           = 1'b0;
        RdData        = 8'h0;
        RdData_valid  = 1'b0;
        ALU_OUT       = 16'h0;
        ALU_OUT_valid = 1'b0;
        repeat (3) @(negedge clck);
        test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clck);
        test_rf_byte;
        test_alu_split;
        test_back_to_back;
        test_overrun;
        test_timeout;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
